// File: rtl/fifo_pop_checker_if.sv
// Pop-side and downstream handshake bundle for fifo_pop_checker.
// slave = the checker, master = whatever drives it (FIFO + downstream).
interface fifo_pop_checker_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ERR_CNT_WIDTH = 8
);
  logic                     pop_valid_i;
  logic [DATA_WIDTH-1:0]    pop_data_i;
  logic                     pop_grant_o;
  logic                     out_valid_o;
  logic [DATA_WIDTH-2:0]    out_data_o;
  logic                     out_ready_i;
  logic                     clr_err_i;
  logic                     err_pulse_o;
  logic [ERR_CNT_WIDTH-1:0] err_count_o;

  modport slave (
    input  pop_valid_i, pop_data_i, out_ready_i, clr_err_i,
    output pop_grant_o, out_valid_o, out_data_o, err_pulse_o, err_count_o
  );

  modport master (
    output pop_valid_i, pop_data_i, out_ready_i, clr_err_i,
    input  pop_grant_o, out_valid_o, out_data_o, err_pulse_o, err_count_o
  );
endinterface

// File: rtl/fifo_pop_checker.sv
// FIFO pop-side consumer: parity-checks each popped word, drops and counts
// bad words, forwards good payloads through a 2-entry output buffer.
module fifo_pop_checker #(
  parameter int DATA_WIDTH    = 8,
  parameter bit PARITY_ODD    = 1'b0,
  parameter int ERR_CNT_WIDTH = 8
) (
  input logic                clk,
  input logic                reset_n,
  fifo_pop_checker_if.slave  bus
);
  localparam int PW = DATA_WIDTH - 1;

  logic [1:0][PW-1:0]       mem;
  logic                     wr_ptr, rd_ptr;
  logic [1:0]               count, count_next;
  logic                     grant_q;
  logic                     err_q;
  logic [ERR_CNT_WIDTH-1:0] err_cnt;

  logic push, parity_ok, wr, bad, rd;

  // Handshake decode; grant is registered so push never loops back combinationally.
  assign push      = bus.pop_valid_i & grant_q;
  assign parity_ok = ((^bus.pop_data_i) == PARITY_ODD);
  assign wr        = push & parity_ok;
  assign bad       = push & ~parity_ok;
  assign rd        = (count != 2'd0) & bus.out_ready_i;

  // Occupancy after this edge; also drives the next grant decision.
  always_comb begin
    count_next = count;
    case ({wr, rd})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  // Output buffer storage, pointers, count and pop grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem     <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      grant_q <= 1'b0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= bus.pop_data_i[PW-1:0];
        wr_ptr      <= ~wr_ptr;
      end
      if (rd) rd_ptr <= ~rd_ptr;
      count   <= count_next;
      // Dropping grant when the buffer will be full guarantees no write at count==2.
      grant_q <= (count_next < 2'd2);
    end
  end

  // Error pulse and saturating error counter; clear wins but still counts a same-cycle error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q   <= 1'b0;
      err_cnt <= '0;
    end else begin
      err_q <= bad;
      if (bus.clr_err_i)
        err_cnt <= ERR_CNT_WIDTH'(bad);
      else if (bad && (err_cnt != '1))
        err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
    end
  end

  assign bus.pop_grant_o = grant_q;
  assign bus.out_valid_o = (count != 2'd0);
  assign bus.out_data_o  = mem[rd_ptr];
  assign bus.err_pulse_o = err_q;
  assign bus.err_count_o = err_cnt;
endmodule

// File: tb/tb_fifo_pop_checker.sv
// Directed bench for fifo_pop_checker (8-bit words, even parity, 2-bit error counter).
module tb_fifo_pop_checker;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   pass = 0;
  int   total = 0;

  fifo_pop_checker_if #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(2)) bus ();

  fifo_pop_checker #(.DATA_WIDTH(8), .PARITY_ODD(1'b0), .ERR_CNT_WIDTH(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.pop_valid_i = 1'b0;
    bus.pop_data_i  = '0;
    bus.out_ready_i = 1'b0;
    bus.clr_err_i   = 1'b0;
    reset_n = 1'b0;
    tick(); tick();
    total++; if (bus.pop_grant_o !== 1'b0) $display("FAIL rst_grant: got %b want 0", bus.pop_grant_o); else pass++;
    total++; if (bus.out_valid_o !== 1'b0) $display("FAIL rst_valid: got %b want 0", bus.out_valid_o); else pass++;
    total++; if (bus.out_data_o !== 7'h00) $display("FAIL rst_data: got %h want 00", bus.out_data_o); else pass++;
    total++; if (bus.err_count_o !== 2'd0) $display("FAIL rst_errcnt: got %0d want 0", bus.err_count_o); else pass++;
    total++; if (bus.err_pulse_o !== 1'b0) $display("FAIL rst_pulse: got %b want 0", bus.err_pulse_o); else pass++;
    reset_n = 1'b1;
    #1;
    total++; if (bus.pop_grant_o !== 1'b0) $display("FAIL rel_grant_early: got %b want 0", bus.pop_grant_o); else pass++;
    bus.out_ready_i = 1'b1;  // ready while empty must do nothing
    tick();
    total++; if (bus.pop_grant_o !== 1'b1) $display("FAIL rel_grant: got %b want 1", bus.pop_grant_o); else pass++;
    total++; if (bus.out_valid_o !== 1'b0) $display("FAIL idle_valid: got %b want 0", bus.out_valid_o); else pass++;
  endtask

  task automatic test_single_good();
    bus.out_ready_i = 1'b1;
    bus.pop_valid_i = 1'b1;
    bus.pop_data_i  = 8'h03;
    tick();
    bus.pop_valid_i = 1'b0;
    total++; if (bus.out_valid_o !== 1'b1) $display("FAIL single_valid: got %b want 1", bus.out_valid_o); else pass++;
    total++; if (bus.out_data_o !== 7'h03) $display("FAIL single_data: got %h want 03", bus.out_data_o); else pass++;
    total++; if (bus.err_pulse_o !== 1'b0) $display("FAIL single_pulse: got %b want 0", bus.err_pulse_o); else pass++;
    tick();
    total++; if (bus.out_valid_o !== 1'b0) $display("FAIL single_drain: got %b want 0", bus.out_valid_o); else pass++;
  endtask

  task automatic test_bad_parity();
    bus.out_ready_i = 1'b1;
    bus.pop_valid_i = 1'b1;
    bus.pop_data_i  = 8'h83;
    tick();
    total++; if (bus.err_pulse_o !== 1'b1) $display("FAIL bad1_pulse: got %b want 1", bus.err_pulse_o); else pass++;
    total++; if (bus.out_valid_o !== 1'b0) $display("FAIL bad1_valid: got %b want 0", bus.out_valid_o); else pass++;
    total++; if (bus.err_count_o !== 2'd1) $display("FAIL bad1_cnt: got %0d want 1", bus.err_count_o); else pass++;
    bus.pop_data_i = 8'h01;
    tick();
    total++; if (bus.err_pulse_o !== 1'b1) $display("FAIL bad2_pulse: got %b want 1", bus.err_pulse_o); else pass++;
    total++; if (bus.err_count_o !== 2'd2) $display("FAIL bad2_cnt: got %0d want 2", bus.err_count_o); else pass++;
    bus.pop_data_i = 8'h05;
    tick();
    bus.pop_valid_i = 1'b0;
    total++; if (bus.err_pulse_o !== 1'b0) $display("FAIL good_pulse: got %b want 0", bus.err_pulse_o); else pass++;
    total++; if (bus.out_valid_o !== 1'b1) $display("FAIL good_valid: got %b want 1", bus.out_valid_o); else pass++;
    total++; if (bus.out_data_o !== 7'h05) $display("FAIL good_data: got %h want 05", bus.out_data_o); else pass++;
    total++; if (bus.err_count_o !== 2'd2) $display("FAIL good_cnt: got %0d want 2", bus.err_count_o); else pass++;
    tick();
    total++; if (bus.out_valid_o !== 1'b0) $display("FAIL bad_drain: got %b want 0", bus.out_valid_o); else pass++;
  endtask

  task automatic test_backpressure();
    bus.out_ready_i = 1'b0;
    bus.pop_valid_i = 1'b1;
    bus.pop_data_i  = 8'h03;
    tick();
    total++; if (bus.pop_grant_o !== 1'b1) $display("FAIL bp1_grant: got %b want 1", bus.pop_grant_o); else pass++;
    total++; if (bus.out_data_o !== 7'h03) $display("FAIL bp1_data: got %h want 03", bus.out_data_o); else pass++;
    bus.pop_data_i = 8'h05;
    tick();
    bus.pop_data_i = 8'h06;
    total++; if (bus.pop_grant_o !== 1'b0) $display("FAIL bp2_grant: got %b want 0", bus.pop_grant_o); else pass++;
    total++; if (bus.out_data_o !== 7'h03) $display("FAIL bp2_data: got %h want 03", bus.out_data_o); else pass++;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (bus.pop_grant_o !== 1'b0) $display("FAIL bp_hold_grant[%0d]: got %b want 0", i, bus.pop_grant_o); else pass++;
      total++; if (bus.out_data_o !== 7'h03) $display("FAIL bp_stable[%0d]: got %h want 03", i, bus.out_data_o); else pass++;
    end
    bus.out_ready_i = 1'b1;
    tick();  // 03 leaves, grant re-opens
    total++; if (bus.out_data_o !== 7'h05) $display("FAIL bp_out2: got %h want 05", bus.out_data_o); else pass++;
    total++; if (bus.pop_grant_o !== 1'b1) $display("FAIL bp_regrant: got %b want 1", bus.pop_grant_o); else pass++;
    tick();  // 05 leaves, held 06 popped
    bus.pop_valid_i = 1'b0;
    total++; if (bus.out_data_o !== 7'h06) $display("FAIL bp_out3: got %h want 06", bus.out_data_o); else pass++;
    total++; if (bus.out_valid_o !== 1'b1) $display("FAIL bp_valid3: got %b want 1", bus.out_valid_o); else pass++;
    tick();
    total++; if (bus.out_valid_o !== 1'b0) $display("FAIL bp_drain: got %b want 0", bus.out_valid_o); else pass++;
  endtask

  task automatic test_err_saturation();
    bus.clr_err_i = 1'b1;
    tick();
    bus.clr_err_i = 1'b0;
    total++; if (bus.err_count_o !== 2'd0) $display("FAIL clr_cnt: got %0d want 0", bus.err_count_o); else pass++;
    bus.pop_valid_i = 1'b1;
    bus.pop_data_i  = 8'h01;
    for (int i = 0; i < 5; i++) begin
      logic [1:0] exp_cnt;
      exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
      tick();
      total++; if (bus.err_count_o !== exp_cnt) $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, bus.err_count_o, exp_cnt); else pass++;
    end
    bus.clr_err_i = 1'b1;
    tick();
    bus.clr_err_i   = 1'b0;
    bus.pop_valid_i = 1'b0;
    total++; if (bus.err_count_o !== 2'd1) $display("FAIL clr_bad_cnt: got %0d want 1", bus.err_count_o); else pass++;
    total++; if (bus.err_pulse_o !== 1'b1) $display("FAIL clr_bad_pulse: got %b want 1", bus.err_pulse_o); else pass++;
    tick();
    total++; if (bus.err_pulse_o !== 1'b0) $display("FAIL sat_pulse_end: got %b want 0", bus.err_pulse_o); else pass++;
  endtask

  task automatic test_reset_mid();
    bus.out_ready_i = 1'b0;
    bus.pop_valid_i = 1'b1;
    bus.pop_data_i  = 8'h03;
    tick();
    bus.pop_data_i = 8'h05;
    tick();
    bus.pop_valid_i = 1'b0;
    total++; if (bus.out_valid_o !== 1'b1) $display("FAIL mid_pre_valid: got %b want 1", bus.out_valid_o); else pass++;
    reset_n = 1'b0;
    #1;
    total++; if (bus.out_valid_o !== 1'b0) $display("FAIL mid_valid: got %b want 0", bus.out_valid_o); else pass++;
    total++; if (bus.pop_grant_o !== 1'b0) $display("FAIL mid_grant: got %b want 0", bus.pop_grant_o); else pass++;
    total++; if (bus.err_count_o !== 2'd0) $display("FAIL mid_cnt: got %0d want 0", bus.err_count_o); else pass++;
    tick();
    reset_n = 1'b1;
    tick();
    total++; if (bus.pop_grant_o !== 1'b1) $display("FAIL mid_regrant: got %b want 1", bus.pop_grant_o); else pass++;
    total++; if (bus.out_valid_o !== 1'b0) $display("FAIL mid_empty: got %b want 0", bus.out_valid_o); else pass++;
    bus.out_ready_i = 1'b1;
    bus.pop_valid_i = 1'b1;
    bus.pop_data_i  = 8'h03;
    tick();
    bus.pop_valid_i = 1'b0;
    total++; if (bus.out_valid_o !== 1'b1) $display("FAIL mid_resume_valid: got %b want 1", bus.out_valid_o); else pass++;
    total++; if (bus.out_data_o !== 7'h03) $display("FAIL mid_resume_data: got %h want 03", bus.out_data_o); else pass++;
  endtask

  initial begin
    test_reset();
    test_single_good();
    test_bad_parity();
    test_backpressure();
    test_err_saturation();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/fifo_pop_checker.md
Name: fifo_pop_checker

Overview:
- Consumer for the pop side of `fifo`. It drives `pop_grant_o` and accepts words on the pop valid/grant handshake.
- Each word carries a parity bit in its MSB. The block checks it, drops bad words and counts them.
- Good payloads are forwarded through a 2-entry output buffer on a valid/ready interface, so full throughput is sustained under downstream backpressure.

Parameters:
- DATA_WIDTH, 8: width of the popped word, including the parity bit (MSB). Must be ≥ 2.
- PARITY_ODD, 0: 0 = even parity over the full word; 1 = odd parity over the full word.
- ERR_CNT_WIDTH, 8: width of the parity-error counter.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- pop_valid_i  in  1  FIFO presents a word
- pop_data_i  in  DATA_WIDTH  word from FIFO; bit DATA_WIDTH-1 is parity
- pop_grant_o  out  1  request FIFO to pop the presented word
- out_valid_o  out  1  payload available downstream
- out_data_o  out  DATA_WIDTH-1  payload, i.e. pop_data_i[DATA_WIDTH-2:0]
- out_ready_i  in  1  downstream accepts payload
- clr_err_i  in  1  synchronous clear of error counter
- err_pulse_o  out  1  one-cycle pulse per dropped word
- err_count_o  out  ERR_CNT_WIDTH  saturating count of dropped words

Behaviour:
- Interface decision: one clock `clk`; `reset_n` is asynchronous, active-low. All state clears immediately on reset_n=0.
- Reset values: pop_grant_o=0, out_valid_o=0, out_data_o=0, err_pulse_o=0, err_count_o=0, buffer count=0.
- Pop handshake: a transfer occurs on a rising edge where pop_valid_i && pop_grant_o. pop_data_i is sampled on that edge only. No other combination consumes a word.
- pop_grant_o is registered: grant_q <= (count_next < 2).
  - It rises on the first edge after reset release.
  - It never depends combinationally on pop_valid_i or out_ready_i.
- Parity check:
  - ok = (^pop_data_i) == PARITY_ODD.
  - ok word: payload is written to the buffer tail.
  - bad word: payload is discarded; err_pulse_o=1 in the next cycle; err_count_o increments, saturating at all-ones.
- Error counter:
  - clr_err_i takes priority; it clears err_count_o to 0.
  - clr_err_i together with an error in the same cycle gives err_count_o=1.
  - err_pulse_o is unaffected by clr_err_i.
- Output buffer: 2-entry circular buffer, 1-bit read/write pointers plus a 2-bit count.
  - out_valid_o = (count != 0); out_data_o = head entry, registered storage only.
  - Downstream transfer occurs when out_valid_o && out_ready_i; the head advances.
  - Latency: a good word accepted on edge N is presented on out_* after edge N (1 cycle). Order is preserved.
- Count update:
  - write and read in the same cycle: count unchanged.
  - write only: +1.
  - read only: −1.
  - A write never occurs while count==2, because the registered grant is low whenever count_next reaches 2.
- out_data_o holds its value while out_valid_o=1 && out_ready_i=0 (stable under backpressure).
- Pointer wrap: both pointers wrap 1→0; the count is the sole full/empty authority.
- out_ready_i while empty: no effect.
- pop_valid_i while grant low: no effect; the word stays in the FIFO.
- Reset mid-operation: buffered payloads are lost, the counter clears, and grant drops immediately. The first grant follows one clock after release.

Test Plan:
- Reset then idle: hold reset_n=0 for 2 cycles, release → pop_grant_o=0 during reset, 1 from the first edge after release; out_valid_o=0, err_count_o=0.
- Single good word: push 0x03 into fifo; pop_valid_i=1, word 0x03 (even parity ok), out_ready_i=1 → out_valid_o=1 one cycle later with out_data_o=0x03; err_pulse_o stays 0.
- Bad parity: words 0x83, 0x01, 0x05 back-to-back → 0x83 and 0x01 dropped, with err_pulse_o high on 2 consecutive cycles and err_count_o=2; out emits only 0x05.
- Backpressure: out_ready_i=0, words 0x03, 0x05, 0x06 offered → first two buffered and pop_grant_o falls; 0x06 is held in the FIFO. Raise out_ready_i → outputs 0x03, 0x05, 0x06 in order, with out_data_o stable while stalled.
- Counter saturation/clear: ERR_CNT_WIDTH=2, 5 bad words → err_count_o sticks at 3. Assert clr_err_i alongside a bad word → err_count_o=1.
- Reset mid-stream: 2 words buffered, reset_n pulsed low → out_valid_o=0 and pop_grant_o=0 immediately; after release, normal streaming resumes with 0x03 passing through.
